fpu_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle fp16 multiplier (fpu_mult) between NREQ requesters.
It captures one requester's operands and issues a single-cycle valid_in pulse to the multiplier.
It then waits for the multiplier's valid_out pulse and routes the result back to the owning requester.
A watchdog returns a quiet NaN and sets a sticky error flag if the multiplier never answers.

---
 rtl/fpu_mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_fpu_mult_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mult_arbiter.sv
// fpu_mult_arbiter: round-robin front end that shares one multi-cycle fp16
// multiplier between NREQ requesters. A granted requester's operands are sent
// to the multiplier with a one-cycle valid pulse. The result is then routed
// back to that requester. A watchdog substitutes a quiet NaN and raises a
// sticky error if the multiplier never answers.
//
// Handshake: a requester holds req_valid and its operands stable until it
// sees its one-cycle req_ready pulse. req_valid is sampled only while the
// arbiter is idle, so a request raised while busy is neither queued nor lost.
// It is simply seen again once the arbiter returns to idle. A response is a
// one-cycle rsp_valid pulse on the owner's bit, and rsp_data is valid in that
// cycle. There is no backpressure on responses.
module fpu_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 mult_valid_in,
  output logic [15:0]          mult_a,
  output logic [15:0]          mult_b,
  input  logic                 mult_valid_out,
  input  logic [15:0]          mult_result,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   owner, owner_d;
  logic [IW-1:0]   last_grant, last_grant_d;
  logic [7:0]      cnt, cnt_d;
  logic [NREQ-1:0] req_ready_d, rsp_valid_d;
  logic [15:0]     rsp_data_d, mult_a_d, mult_b_d;
  logic            mult_valid_in_d, busy_d, timeout_err_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [SW-1:0]   sum;

  assign dbg_state = state;

  // Round-robin search: the first set request strictly after last_grant, with wrap-around
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    sum   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_grant} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is produced one cycle ahead and registered
  always_comb begin
    state_d         = state;
    owner_d         = owner;
    last_grant_d    = last_grant;
    cnt_d           = cnt;
    req_ready_d     = '0;
    rsp_valid_d     = '0;
    rsp_data_d      = rsp_data;
    mult_valid_in_d = 1'b0;
    mult_a_d        = mult_a;
    mult_b_d        = mult_b;
    timeout_err_d   = timeout_err;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d            = pick;
          mult_a_d           = req_a[{pick, 4'b0000} +: 16];
          mult_b_d           = req_b[{pick, 4'b0000} +: 16];
          req_ready_d[pick]  = 1'b1;
          mult_valid_in_d    = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + 8'd1;
        // A result arriving in the watchdog's last cycle still wins
        if (mult_valid_out) begin
          rsp_data_d         = mult_result;
          rsp_valid_d[owner] = 1'b1;
          state_d            = RESP;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          rsp_data_d         = QNAN;
          timeout_err_d      = 1'b1;
          rsp_valid_d[owner] = 1'b1;
          state_d            = RESP;
        end
      end
      RESP: begin
        last_grant_d = owner;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; async reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= '0;
      last_grant    <= IW'(NREQ - 1);
      cnt           <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      mult_valid_in <= 1'b0;
      mult_a        <= '0;
      mult_b        <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      last_grant    <= last_grant_d;
      cnt           <= cnt_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      mult_valid_in <= mult_valid_in_d;
      mult_a        <= mult_a_d;
      mult_b        <= mult_b_d;
      busy          <= busy_d;
      timeout_err   <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Directed testbench for fpu_mult_arbiter with a small latency-programmable
// fp16 multiplier model. The model can also be told never to answer.
module tb_fpu_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [16*NREQ-1:0]   req_a = '0;
  logic [16*NREQ-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_ready, rsp_valid;
  logic [15:0]          rsp_data, mult_a, mult_b, mult_result;
  logic                 mult_valid_in, mult_valid_out, busy, timeout_err;
  logic [1:0]           dbg_state;

  int errors = 0;
  int checks = 0;

  // clock
  always #5 clk = ~clk;

  fpu_mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mult_valid_in(mult_valid_in), .mult_a(mult_a), .mult_b(mult_b),
    .mult_valid_out(mult_valid_out), .mult_result(mult_result),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // multiplier model: products of the operand pairs used below
  function automatic logic [15:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: mul_ref = 16'h4000;
      32'h4200_4000: mul_ref = 16'h4600;
      32'h7C00_0000: mul_ref = 16'h7E00;
      32'hBC00_4000: mul_ref = 16'hC000;
      default:       mul_ref = 16'hDEAD;
    endcase
  endfunction

  int          lat  = 5;
  logic        dead = 1'b0;
  logic        m_pend;
  logic [7:0]  m_cd;
  logic [15:0] m_res;

  // valid_out pulses for one cycle, lat cycles after valid_in is sampled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_cd   <= '0;
      m_res  <= '0;
    end else if (mult_valid_in) begin
      m_pend <= 1'b1;
      m_cd   <= 8'(lat - 1);
      m_res  <= mul_ref(mult_a, mult_b);
    end else if (m_pend) begin
      if (m_cd == 8'd0) m_pend <= 1'b0;
      else m_cd <= m_cd - 8'd1;
    end
  end
  assign mult_valid_out = m_pend && (m_cd == 8'd0) && !dead;
  assign mult_result    = m_res;

  // driver: reset the DUT and the model
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    dead      = 1'b0;
    lat       = 5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver: one isolated operation from requester idx; returns what was observed
  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                       output logic [NREQ-1:0] gvec, output logic [15:0] ga,
                       output logic [15:0] gb, output int vin_cyc,
                       output logic [NREQ-1:0] rvec, output logic [15:0] rdata,
                       output int rlat, output int bcyc, output logic rerr);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid[idx]      = 1'b1;
    gvec = '0; ga = '0; gb = '0; vin_cyc = 0;
    rvec = '0; rdata = '0; rlat = -1; bcyc = 0; rerr = 1'bx;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gvec = req_ready;
        ga   = mult_a;
        gb   = mult_b;
        if (mult_valid_in) vin_cyc++;
        if (busy) bcyc++;
        break;
      end
    end
    req_valid[idx] = 1'b0;
    if (gvec != '0) begin
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (busy) bcyc++;
        if (mult_valid_in) vin_cyc++;
        if (rsp_valid != '0) begin
          rvec  = rsp_valid;
          rdata = rsp_data;
          rlat  = n;
          rerr  = timeout_err;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== '0) begin
      errors++; $display("FAIL reset_handshake: got %b expected 0", {req_ready, rsp_valid});
    end
    checks++;
    if ({mult_valid_in, busy, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {mult_valid_in, busy, timeout_err});
    end
    checks++;
    if ({rsp_data, mult_a, mult_b} !== 48'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {rsp_data, mult_a, mult_b});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NREQ-1:0] gvec, rvec;
    logic [15:0] ga, gb, rdata;
    int vin_cyc, rlat, bcyc;
    logic rerr;
    do_reset();
    do_op(0, 16'h3C00, 16'h4000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if (gvec !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", gvec); end
    checks++;
    if ({ga, gb} !== {16'h3C00, 16'h4000}) begin
      errors++; $display("FAIL single_operands: got %h expected 3c004000", {ga, gb});
    end
    checks++;
    if (vin_cyc !== 1) begin errors++; $display("FAIL single_valid_in_len: got %0d expected 1", vin_cyc); end
    checks++;
    if (rlat !== 6) begin errors++; $display("FAIL single_latency: got %0d expected 6", rlat); end
    checks++;
    if (rvec !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0001", rvec); end
    checks++;
    if (rdata !== 16'h4000) begin errors++; $display("FAIL single_rsp_data: got %h expected 4000", rdata); end
    checks++;
    if (bcyc !== 7) begin errors++; $display("FAIL single_busy_len: got %0d expected 7", bcyc); end
    @(negedge clk);
    checks++;
    if ({busy, rsp_valid} !== 5'b0) begin
      errors++; $display("FAIL single_idle_after: got %b expected 00000", {busy, rsp_valid});
    end
    checks++;
    if (rsp_data !== 16'h4000) begin errors++; $display("FAIL single_data_hold: got %h expected 4000", rsp_data); end
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0] g_vec[4];
    logic [NREQ-1:0] r_vec[4];
    logic [15:0]     r_dat[4];
    int              g_time[4];
    logic [NREQ-1:0] exp_v;
    int ng, nr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'h4200;
      req_b[16*i +: 16] = 16'h4000;
      g_vec[i] = '0; r_vec[i] = '0; r_dat[i] = '0; g_time[i] = -100;
    end
    req_valid = 4'b1111;
    ng = 0; nr = 0;
    for (int n = 0; n < 80 && nr < 4; n++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 4) begin
        g_vec[ng]  = req_ready;
        g_time[ng] = n;
        req_valid  = req_valid & ~req_ready;
        ng++;
      end
      if (rsp_valid != '0 && nr < 4) begin
        r_vec[nr] = rsp_valid;
        r_dat[nr] = rsp_data;
        nr++;
      end
    end
    req_valid = '0;
    checks++;
    if (ng !== 4 || nr !== 4) begin
      errors++; $display("FAIL simul_count: got %0d grants %0d rsps expected 4 4", ng, nr);
    end
    for (int i = 0; i < 4; i++) begin
      exp_v = 4'b0001 << i;
      checks++;
      if (g_vec[i] !== exp_v) begin
        errors++; $display("FAIL simul_grant%0d: got %b expected %b", i, g_vec[i], exp_v);
      end
      checks++;
      if (r_vec[i] !== exp_v || r_dat[i] !== 16'h4600) begin
        errors++; $display("FAIL simul_rsp%0d: got %b/%h expected %b/4600", i, r_vec[i], r_dat[i], exp_v);
      end
      if (i > 0) begin
        checks++;
        if (g_time[i] - g_time[i-1] !== 8) begin
          errors++; $display("FAIL simul_spacing%0d: got %0d expected 8", i, g_time[i] - g_time[i-1]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g_vec[4];
    logic [NREQ-1:0] r_vec[4];
    logic [NREQ-1:0] exp_g[4];
    int ng, nr;
    do_reset();
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    for (int i = 0; i < 4; i++) begin g_vec[i] = '0; r_vec[i] = '0; end
    req_a[15:0]  = 16'h3C00; req_b[15:0]  = 16'h4000;
    req_a[47:32] = 16'h4200; req_b[47:32] = 16'h4000;
    req_valid = 4'b0101;
    ng = 0; nr = 0;
    for (int n = 0; n < 80 && nr < 4; n++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 4) begin
        g_vec[ng] = req_ready;
        ng++;
        if (ng == 4) req_valid = '0;
      end
      if (rsp_valid != '0 && nr < 4) begin
        r_vec[nr] = rsp_valid;
        nr++;
      end
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g_vec[i] !== exp_g[i] || r_vec[i] !== exp_g[i]) begin
        errors++; $display("FAIL fair_order%0d: got %b/%b expected %b", i, g_vec[i], r_vec[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_timeout_edge();
    logic [NREQ-1:0] gvec, rvec;
    logic [15:0] ga, gb, rdata;
    int vin_cyc, rlat, bcyc;
    logic rerr;
    do_reset();
    // answer in the watchdog's final WAIT cycle: result wins
    lat = TIMEOUT;
    do_op(1, 16'h3C00, 16'h4000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if ({rvec, rdata, rerr} !== {4'b0010, 16'h4000, 1'b0} || rlat !== TIMEOUT + 1) begin
      errors++; $display("FAIL edge_collision: got %b/%h/%b lat %0d expected 0010/4000/0 lat %0d",
                         rvec, rdata, rerr, rlat, TIMEOUT + 1);
    end
    // answer one cycle too late: watchdog fires, late pulse in RESP ignored
    lat = TIMEOUT + 1;
    do_op(1, 16'h3C00, 16'h4000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if ({rvec, rdata, rerr} !== {4'b0010, 16'h7E00, 1'b1} || rlat !== TIMEOUT + 1) begin
      errors++; $display("FAIL edge_late: got %b/%h/%b lat %0d expected 0010/7e00/1 lat %0d",
                         rvec, rdata, rerr, rlat, TIMEOUT + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rsp_valid, rsp_data} !== {1'b0, 4'b0000, 16'h7E00}) begin
      errors++; $display("FAIL edge_late_ignored: got %b/%b/%h expected 0/0000/7e00", busy, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_watchdog();
    logic [NREQ-1:0] gvec, rvec;
    logic [15:0] ga, gb, rdata;
    int vin_cyc, rlat, bcyc;
    logic rerr;
    do_reset();
    dead = 1'b1;
    do_op(1, 16'h3C00, 16'h4000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if (rlat !== TIMEOUT + 1) begin
      errors++; $display("FAIL wd_latency: got %0d expected %0d", rlat, TIMEOUT + 1);
    end
    checks++;
    if ({rvec, rdata, rerr} !== {4'b0010, 16'h7E00, 1'b1}) begin
      errors++; $display("FAIL wd_response: got %b/%h/%b expected 0010/7e00/1", rvec, rdata, rerr);
    end
    dead = 1'b0;
    do_op(3, 16'h4200, 16'h4000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if ({rvec, rdata, rerr} !== {4'b1000, 16'h4600, 1'b1} || rlat !== 6) begin
      errors++; $display("FAIL wd_sticky: got %b/%h/%b lat %0d expected 1000/4600/1 lat 6", rvec, rdata, rerr, rlat);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky_idle: got %b expected 1", timeout_err); end
  endtask

  task automatic test_reset_in_wait();
    logic [NREQ-1:0] gvec;
    int nrsp;
    do_reset();
    req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000;
    req_valid   = 4'b0001;
    gvec = '0;
    for (int n = 0; n < 10 && gvec == '0; n++) begin
      @(negedge clk);
      if (req_ready != '0) gvec = req_ready;
    end
    req_valid = '0;
    checks++;
    if (gvec !== 4'b0001 || mult_valid_in !== 1'b1) begin
      errors++; $display("FAIL rstw_grant: got %b/%b expected 0001/1", gvec, mult_valid_in);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, dbg_state} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL rstw_in_wait: got %b/%0d expected 1/2", busy, dbg_state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, mult_valid_in, busy, timeout_err} !== 11'b0 ||
        {rsp_data, mult_a, mult_b} !== 48'h0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rstw_async: got %b/%h/%0d expected all zero",
                         {req_ready, rsp_valid, mult_valid_in, busy, timeout_err},
                         {rsp_data, mult_a, mult_b}, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) nrsp++;
    end
    checks++;
    if (nrsp !== 0) begin errors++; $display("FAIL rstw_no_rsp: got %0d expected 0", nrsp); end
    req_a[63:48] = 16'h4200; req_b[63:48] = 16'h4000;
    req_valid = 4'b1001;
    gvec = '0;
    for (int n = 0; n < 10 && gvec == '0; n++) begin
      @(negedge clk);
      if (req_ready != '0) gvec = req_ready;
    end
    req_valid = req_valid & ~gvec;
    checks++;
    if (gvec !== 4'b0001) begin errors++; $display("FAIL rstw_first_grant: got %b expected 0001", gvec); end
    gvec = '0;
    for (int n = 0; n < 20 && gvec == '0; n++) begin
      @(negedge clk);
      if (req_ready != '0) gvec = req_ready;
    end
    req_valid = '0;
    checks++;
    if (gvec !== 4'b1000) begin errors++; $display("FAIL rstw_second_grant: got %b expected 1000", gvec); end
  endtask

  task automatic test_special();
    logic [NREQ-1:0] gvec, rvec;
    logic [15:0] ga, gb, rdata;
    int vin_cyc, rlat, bcyc;
    logic rerr;
    do_reset();
    do_op(2, 16'h7C00, 16'h0000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if ({rvec, rdata, rerr} !== {4'b0100, 16'h7E00, 1'b0} || rlat !== 6) begin
      errors++; $display("FAIL special_inf_zero: got %b/%h/%b lat %0d expected 0100/7e00/0 lat 6", rvec, rdata, rerr, rlat);
    end
    do_op(3, 16'hBC00, 16'h4000, gvec, ga, gb, vin_cyc, rvec, rdata, rlat, bcyc, rerr);
    checks++;
    if ({rvec, rdata, rerr} !== {4'b1000, 16'hC000, 1'b0}) begin
      errors++; $display("FAIL special_neg: got %b/%h/%b expected 1000/c000/0", rvec, rdata, rerr);
    end
  endtask

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout_edge();
    test_watchdog();
    test_reset_in_wait();
    test_special();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
